// File: rtl/led_seq_ctrl.sv
// Bus-mapped LED pattern sequencer: static, blink and rotate sequences stepped
// from a divided tick, with optional 16-level PWM dimming and register readback.
module led_seq_ctrl #(
  parameter logic [7:0] BASE_ADDR = 8'hC4,
  parameter int         TICK_DIV  = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic [7:0] LED_OUT,
  output logic       STEP
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROL    = 2'd2,
    MODE_ROR    = 2'd3
  } mode_e;

  function automatic logic [7:0] rol8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] ror8(input logic [7:0] v);
    return {v[0], v[7:1]};
  endfunction

  logic [3:0]    ctrl_r;
  logic [7:0]    pattern_r;
  logic [7:0]    period_r;
  logic [3:0]    bright_r;
  state_e        state_r;
  logic [PW-1:0] presc_r;
  logic [7:0]    stepcnt_r;
  logic [7:0]    work_r;
  logic          phase_r;
  logic [3:0]    pwm_cnt_r;
  logic [7:0]    led_r;
  logic          step_r;

  logic [7:0] off_s;
  logic       hit_s;
  logic       wr_ctrl_s;
  logic       wr_pattern_s;
  logic       wr_period_s;
  logic       wr_bright_s;
  logic [7:0] rd_data_s;
  logic       drv_s;
  mode_e      mode_s;
  logic [7:0] period_eff_s;
  logic       tick_s;
  logic       step_s;
  logic [7:0] raw_s;
  logic       gate_s;

  // Address decode, write strobes and readback mux.
  always_comb begin
    off_s        = BUS_ADDR - BASE_ADDR;
    hit_s        = (off_s < 8'd4);
    wr_ctrl_s    = 1'b0;
    wr_pattern_s = 1'b0;
    wr_period_s  = 1'b0;
    wr_bright_s  = 1'b0;
    rd_data_s    = 8'h00;
    if (hit_s) begin
      case (off_s[1:0])
        2'd0: begin
          wr_ctrl_s = BUS_WE;
          rd_data_s = {4'h0, ctrl_r};
        end
        2'd1: begin
          wr_pattern_s = BUS_WE;
          rd_data_s    = pattern_r;
        end
        2'd2: begin
          wr_period_s = BUS_WE;
          rd_data_s   = period_r;
        end
        2'd3: begin
          wr_bright_s = BUS_WE;
          rd_data_s   = {4'h0, bright_r};
        end
        default: rd_data_s = 8'h00;
      endcase
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // The bus is only ever driven on an in-range read outside reset.
  assign drv_s    = !RESET && !BUS_WE && hit_s;
  assign BUS_DATA = drv_s ? rd_data_s : 8'hzz;

  // Tick/step detection and the raw and dimmed LED image.
  always_comb begin
    mode_s       = mode_e'(ctrl_r[2:1]);
    period_eff_s = (period_r == 8'd0) ? 8'd1 : period_r;
    tick_s       = (state_r == ST_RUN) && (presc_r == TICK_LAST);
    step_s       = tick_s && (stepcnt_r >= (period_eff_s - 8'd1));
    if (state_r == ST_IDLE) begin
      raw_s = pattern_r;
    end else if ((mode_s == MODE_BLINK) && phase_r) begin
      raw_s = 8'h00;
    end else begin
      raw_s = work_r;
    end
    gate_s = !ctrl_r[3] || (bright_r == 4'hF) || (pwm_cnt_r < bright_r);
  end

  // Software-visible configuration registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ctrl_r    <= 4'h0;
      pattern_r <= 8'h00;
      period_r  <= 8'd100;
      bright_r  <= 4'hF;
    end else begin
      if (wr_ctrl_s) begin
        ctrl_r <= BUS_DATA[3:0];
      end
      if (wr_pattern_s) begin
        pattern_r <= BUS_DATA;
      end
      if (wr_period_s) begin
        period_r <= BUS_DATA;
      end
      if (wr_bright_s) begin
        bright_r <= BUS_DATA[3:0];
      end
    end
  end

  // Sequencer FSM with its counters and registered LED/STEP outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      presc_r   <= {PW{1'b0}};
      stepcnt_r <= 8'd0;
      work_r    <= 8'h00;
      phase_r   <= 1'b0;
      pwm_cnt_r <= 4'd0;
      led_r     <= 8'h00;
      step_r    <= 1'b0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 4'd1;
      step_r    <= step_s;
      led_r     <= raw_s & {8{gate_s}};
      case (state_r)
        ST_IDLE: begin
          presc_r   <= {PW{1'b0}};
          stepcnt_r <= 8'd0;
          phase_r   <= 1'b0;
          work_r    <= wr_pattern_s ? BUS_DATA : pattern_r;
          if (wr_ctrl_s && BUS_DATA[0]) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (wr_ctrl_s) begin
            // Any CTRL write restarts the timebase; a pending step action is dropped.
            presc_r   <= {PW{1'b0}};
            stepcnt_r <= 8'd0;
            phase_r   <= 1'b0;
            if (!BUS_DATA[0]) begin
              state_r <= ST_IDLE;
              work_r  <= pattern_r;
            end
          end else begin
            presc_r <= tick_s ? {PW{1'b0}} : (presc_r + PW'(1'b1));
            if (step_s) begin
              stepcnt_r <= 8'd0;
            end else if (tick_s) begin
              stepcnt_r <= stepcnt_r + 8'd1;
            end
            if (wr_pattern_s) begin
              work_r  <= BUS_DATA;
              phase_r <= 1'b0;
            end else if (step_s) begin
              case (mode_s)
                MODE_BLINK: phase_r <= !phase_r;
                MODE_ROL:   work_r  <= rol8(work_r);
                MODE_ROR:   work_r  <= ror8(work_r);
                default:    work_r  <= work_r;
              endcase
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign LED_OUT = led_r;
  assign STEP    = step_r;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with a cycle-level behavioural model and literal pins.
module tb_led_seq_ctrl;

  localparam logic [7:0] BASE = 8'hC4;
  localparam int         T    = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic [7:0] LED_OUT;
  logic       STEP;
  wire  [7:0] bus_w;
  logic       tb_drv;
  logic [7:0] tb_val;

  assign bus_w = tb_drv ? tb_val : 8'hzz;

  led_seq_ctrl #(.BASE_ADDR(BASE), .TICK_DIV(T)) dut (
    .CLK(CLK), .RESET(RESET), .BUS_DATA(bus_w), .BUS_ADDR(BUS_ADDR),
    .BUS_WE(BUS_WE), .LED_OUT(LED_OUT), .STEP(STEP)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // model state
  int         m_ctrl, m_pat, m_per, m_bri, m_work, m_age, m_tk, m_pwm;
  bit         m_run, m_phase;
  logic [7:0] m_led;
  logic       m_step;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_pat = 0; m_per = 100; m_bri = 15; m_work = 0;
    m_age = 0; m_tk = 0; m_pwm = 0; m_run = 1'b0; m_phase = 1'b0;
    m_led = 8'h00; m_step = 1'b0;
  endtask

  // Advance the model by one rising edge, using the bus inputs present at that edge.
  task automatic model_edge();
    logic [7:0] off;
    int  raw, per_eff, mode;
    bit  in_rng, wr_c, wr_p, tick, stp, gate;
    off     = BUS_ADDR - BASE;
    in_rng  = (off < 8'd4);
    wr_c    = BUS_WE && in_rng && (off == 8'd0);
    wr_p    = BUS_WE && in_rng && (off == 8'd1);
    mode    = (m_ctrl >> 1) & 3;
    gate    = ((m_ctrl & 8) == 0) || (m_bri == 15) || (m_pwm < m_bri);
    if (!m_run) raw = m_pat;
    else if (mode == 1 && m_phase) raw = 0;
    else raw = m_work;
    per_eff = (m_per == 0) ? 1 : m_per;
    tick    = m_run && (((m_age + 1) % T) == 0);
    stp     = tick && (m_tk + 1 >= per_eff);
    m_led   = gate ? 8'(raw) : 8'h00;
    m_step  = stp;
    m_pwm   = (m_pwm + 1) % 16;
    m_age   = m_age + 1;
    if (tick) m_tk = stp ? 0 : m_tk + 1;
    if (stp && !wr_c && !wr_p) begin
      if (mode == 1) m_phase = !m_phase;
      else if (mode == 2) m_work = ((m_work << 1) | (m_work >> 7)) & 255;
      else if (mode == 3) m_work = (m_work >> 1) | ((m_work & 1) << 7);
    end
    if (wr_c) begin
      m_ctrl = tb_val & 15; m_age = 0; m_tk = 0; m_phase = 1'b0;
      if (tb_val[0]) m_run = 1'b1;
      else begin m_run = 1'b0; m_work = m_pat; end
    end
    if (wr_p) begin m_pat = tb_val; m_work = tb_val; m_phase = 1'b0; end
    if (BUS_WE && in_rng && off == 8'd2) m_per = tb_val;
    if (BUS_WE && in_rng && off == 8'd3) m_bri = tb_val & 15;
    if (!m_run) begin m_age = 0; m_tk = 0; m_phase = 1'b0; m_work = m_pat; end
  endtask

  // One clock: model follows the rising edge, stimulus resumes at the falling edge.
  task automatic cyc();
    @(posedge CLK);
    if (RESET) model_reset();
    else model_edge();
    @(negedge CLK);
  endtask

  task automatic wr_a(input logic [7:0] a, input logic [7:0] d);
    BUS_WE = 1'b1; BUS_ADDR = a; tb_drv = 1'b1; tb_val = d;
    cyc();
    BUS_WE = 1'b0; tb_drv = 1'b0; BUS_ADDR = 8'h00;
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    wr_a(BASE + 8'(off), d);
  endtask

  task automatic rd(input int off, input logic [7:0] exp, input string nm);
    BUS_WE = 1'b0; BUS_ADDR = BASE + 8'(off); tb_drv = 1'b0;
    #1;
    chk(nm, {8'h00, bus_w}, {8'h00, exp});
    BUS_ADDR = 8'h00;
  endtask

  // Block must not drive: the bench holds 00, any block drive would disturb it.
  task automatic zchk(input logic [7:0] a, input logic we, input string nm);
    BUS_ADDR = a; BUS_WE = we; tb_drv = 1'b1; tb_val = 8'h00;
    #1;
    chk(nm, {8'h00, bus_w}, 16'h0000);
  endtask

  task automatic wait_step(input int exp, input string nm);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!STEP && n < 1000);
    chk(nm, 16'(n), 16'(exp));
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge CLK) begin
    if (chk_en && !RESET) begin
      chk("led_model", {8'h00, LED_OUT}, {8'h00, m_led});
      chk("step_model", {15'd0, STEP}, {15'd0, m_step});
    end
  end

  initial begin
    int on, off_cnt, other, steps;
    RESET = 1'b1; BUS_WE = 1'b0; BUS_ADDR = 8'h00; tb_drv = 1'b0; tb_val = 8'h00;
    model_reset();
    repeat (3) cyc();
    RESET = 1'b0;
    chk_en = 1'b1;
    rd(0, 8'h00, "rst_ctrl");
    rd(1, 8'h00, "rst_pattern");
    rd(2, 8'h64, "rst_period");
    rd(3, 8'h0F, "rst_bright");

    // static
    wr(1, 8'hA5);
    chk("static_led_1edge", {8'h00, LED_OUT}, 16'h0000);
    cyc();
    chk("static_led_2edge", {8'h00, LED_OUT}, 16'h00A5);
    wr(0, 8'h01);
    wait_step(400, "static_first_step");
    wait_step(400, "static_step_interval");
    chk("static_led_hold", {8'h00, LED_OUT}, 16'h00A5);
    zchk(BASE + 8'd4, 1'b0, "oor_hi_z");
    zchk(BASE - 8'd1, 1'b0, "oor_lo_z");
    tb_drv = 1'b0;
    wr_a(BASE + 8'd4, 8'h3C);
    rd(1, 8'hA5, "oor_write_ignored");
    rd(0, 8'h01, "ctrl_readback");

    // rotate-left
    wr(1, 8'h81);
    wr(2, 8'h02);
    wr(0, 8'h05);
    for (int n = 1; n <= 65; n++) begin
      cyc();
      if (n == 9)  chk("rol_8",  {8'h00, LED_OUT}, 16'h0003);
      if (n == 17) chk("rol_16", {8'h00, LED_OUT}, 16'h0006);
      if (n == 25) chk("rol_24", {8'h00, LED_OUT}, 16'h000C);
      if (n == 65) chk("rol_64", {8'h00, LED_OUT}, 16'h0081);
    end

    // blink plus collision
    wr(1, 8'hF0);
    wr(2, 8'h01);
    wr(0, 8'h03);
    for (int n = 1; n <= 11; n++) begin
      cyc();
      if (n == 2)  chk("blink_on",   {8'h00, LED_OUT}, 16'h00F0);
      if (n == 6)  chk("blink_off",  {8'h00, LED_OUT}, 16'h0000);
      if (n == 10) chk("blink_on2",  {8'h00, LED_OUT}, 16'h00F0);
    end
    wr(1, 8'h0F);
    chk("collision_step", {15'd0, STEP}, 16'h0001);
    cyc();
    chk("collision_led", {8'h00, LED_OUT}, 16'h000F);

    // PWM
    wr(1, 8'hFF);
    wr(3, 8'h04);
    wr(0, 8'h09);
    cyc();
    on = 0; other = 0;
    for (int n = 0; n < 32; n++) begin
      cyc();
      if (LED_OUT == 8'hFF) on++;
      else if (LED_OUT != 8'h00) other++;
    end
    chk("pwm4_on", 16'(on), 16'd8);
    chk("pwm4_other", 16'(other), 16'd0);
    wr(3, 8'h0F);
    cyc();
    on = 0;
    for (int n = 0; n < 16; n++) begin
      cyc();
      if (LED_OUT == 8'hFF) on++;
    end
    chk("pwm15_on", 16'(on), 16'd16);
    wr(3, 8'h00);
    cyc();
    off_cnt = 0;
    for (int n = 0; n < 16; n++) begin
      cyc();
      if (LED_OUT == 8'h00) off_cnt++;
    end
    chk("pwm0_off", 16'(off_cnt), 16'd16);

    // bus contention and period drop
    zchk(BASE + 8'd1, 1'b1, "we_no_drive");
    cyc();
    BUS_WE = 1'b0; tb_drv = 1'b0;
    wr(3, 8'h0F);
    wr(1, 8'h3C);
    wr(2, 8'd10);
    wr(0, 8'h01);
    repeat (18) cyc();
    wr(2, 8'd1);
    chk("period_drop_nostep", {15'd0, STEP}, 16'h0000);
    cyc();
    chk("period_drop_step", {15'd0, STEP}, 16'h0001);
    cyc();

    // reset mid-run
    #2;
    RESET = 1'b1;
    zchk(BASE + 8'd2, 1'b0, "rst_bus_z");
    chk("rst_led_async", {8'h00, LED_OUT}, 16'h0000);
    tb_drv = 1'b0;
    model_reset();
    cyc();
    cyc();
    RESET = 1'b0;
    rd(0, 8'h00, "rst2_ctrl");
    rd(1, 8'h00, "rst2_pattern");
    rd(2, 8'h64, "rst2_period");
    rd(3, 8'h0F, "rst2_bright");
    steps = 0;
    for (int n = 0; n < 30; n++) begin
      cyc();
      if (STEP) steps++;
    end
    chk("no_step_after_reset", 16'(steps), 16'd0);
    wr(2, 8'd2);
    wr(0, 8'h01);
    wait_step(8, "first_step_after_en");
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Bus-mapped LED pattern sequencer for LED[15:8]-class outputs, sharing the 8-bit processor data bus with the other peripherals. Software writes a pattern, mode, step period and brightness. The block autonomously sequences the LEDs (static, blink, rotate left/right) with optional 16-level PWM dimming. Registers are readable back over the bus.

Parameters:
BASE_ADDR, 8'hC4, first of 4 consecutive register addresses (BASE..BASE+3)
TICK_DIV, 50000, CLK cycles per tick (1 ms at 50 MHz); must be >= 2

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-high reset
BUS_DATA  inout  8  shared data bus; written by CPU, driven by block on reads
BUS_ADDR  input  8  bus address
BUS_WE  input  1  1 = CPU write cycle, 0 = read/idle
LED_OUT  output  8  registered LED drive
STEP  output  1  one-cycle pulse on every sequence step

Behaviour:
- Register map:
  - BASE+0 CTRL: [0] EN, [2:1] MODE (0 static, 1 blink, 2 rotate-left, 3 rotate-right), [3] PWM_EN, [7:4] read 0.
  - BASE+1 PATTERN.
  - BASE+2 PERIOD: ticks per step; 0 treated as 1.
  - BASE+3 BRIGHT: [3:0] duty, [7:4] read 0.
- Reset values: CTRL=0, PATTERN=0, PERIOD=8'd100, BRIGHT=4'hF, work=0, phase=0, all counters 0, LED_OUT=0, STEP=0, BUS_DATA=Z.
- Write: register updates on the rising edge where BUS_WE=1 and BUS_ADDR hits. LED_OUT reflects the new value one edge later (2-edge write-to-LED latency).
- Read: when BUS_WE=0 and BUS_ADDR in BASE..BASE+3, BUS_DATA is driven combinationally with the register contents. Otherwise BUS_DATA=Z. Never driven while BUS_WE=1.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 on the wrap cycle.
- Step counter: increments on tick. When tick and count >= max(PERIOD,1)-1, it clears and step fires. STEP is a registered copy of step.
- Lowering PERIOD below the current count gives a step on the next tick. No wrap-through-255 delay.
- FSM:
  - IDLE: EN=0. Prescaler, step counter and phase held at 0. work=PATTERN. No STEP.
  - IDLE->RUN: on EN=1 write. Counters start from 0, so the first step comes exactly PERIOD*TICK_DIV cycles after the write edge.
  - RUN->IDLE: on EN=0 write, next edge. work reloads PATTERN.
- Step action in RUN:
  - static: none.
  - blink: phase toggles.
  - rotate-left: work={work[6:0],work[7]}.
  - rotate-right: work={work[0],work[7:1]}.
- Any CTRL write: clears prescaler, step counter and phase.
- PATTERN write: loads work and clears phase. If it coincides with a step, the write wins and that step's rotate/toggle is dropped. STEP still pulses.
- Raw pattern: raw = (MODE==blink && phase) ? 8'h00 : work. In IDLE, raw = PATTERN.
- PWM:
  - 4-bit pwm_cnt free-runs every CLK, wraps 15->0.
  - gate = !PWM_EN || BRIGHT==4'hF || pwm_cnt < BRIGHT.
  - BRIGHT=0 with PWM_EN gives all LEDs off.
- Output: LED_OUT <= raw & {8{gate}} on every edge.
- Reset mid-operation: all state returns to reset values immediately (async). First step after release requires a new EN write.
- Writes to addresses outside the range are ignored. Reads outside the range leave the bus at Z.

Test Plan:
- Reset/readback (TICK_DIV=4): assert RESET mid-run. LED_OUT=0 and BUS_DATA=Z asynchronously. After release, reads of BASE..BASE+3 return 00,00,64,0F.
- Static: write PATTERN=A5, CTRL=01. LED_OUT=A5 two edges after the PATTERN write. STEP pulses every 400 cycles (PERIOD=100), LED unchanged.
- Rotate-left: PATTERN=81, PERIOD=2, CTRL=05. After 8, 16, 24 cycles LED_OUT=03, 06, 0C. After 64 cycles LED_OUT=81 again.
- Blink plus collision: PATTERN=F0, PERIOD=1, CTRL=03. LED_OUT alternates F0/00 every 4 cycles. A PATTERN=0F write on a step cycle gives 0F with phase 0, and STEP still pulses.
- PWM: PATTERN=FF, BRIGHT=4, CTRL=09. LED_OUT=FF for exactly 4 of every 16 cycles. BRIGHT=F gives constant FF. BRIGHT=0 gives constant 00.
- Bus contention: BUS_WE=1 at BASE+1 never sees the block driving. PERIOD dropped from 10 to 1 mid-count gives a step on the very next tick.
